// File: rtl/seq_div_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_div_pkg                                                      |
// | Shared constants for the sequential restoring divider.           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package seq_div_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DZERO = 2'd2;

    localparam int DEFAULT_WIDTH = 4;

    // Wide enough to hold the iteration index for any legal width.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_WIDTH = cnt_width(DEFAULT_WIDTH);

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +------------------------------------------------------------------+
// | div_step                                                         |
// | One combinational restoring-division iteration (trial subtract). |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_r,
    input  logic             i_q_msb,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_r,
    output logic             o_q_bit
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;

    // The partial remainder stays below the divisor, so its top bit is
    // always zero and WIDTH bits are enough to carry it between steps.
    assign w_shift  = {i_r, i_q_msb};
    assign w_borrow = (w_shift < {1'b0, i_d});
    assign w_diff   = w_shift[WIDTH-1:0] - i_d;

    assign o_r     = w_borrow ? w_shift[WIDTH-1:0] : w_diff;
    assign o_q_bit = ~w_borrow;

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_divider                                                      |
// | Multi-cycle unsigned restoring divider with start/done handshake.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_r;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;

    logic [WIDTH-1:0] w_r_next;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_q_next;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_r     (r_r),
        .i_q_msb (r_q[WIDTH-1]),
        .i_d     (r_d),
        .o_r     (w_r_next),
        .o_q_bit (w_q_bit)
    );

    assign w_q_next = {r_q[WIDTH-2:0], w_q_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_q     <= '0;
            r_d     <= '0;
            r_r     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_q     <= dividend;
                        r_d     <= divisor;
                        r_r     <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_dbz   <= 1'b0;
                        r_state <= (divisor != '0) ? ST_RUN : ST_DZERO;
                    end
                end
                ST_RUN: begin
                    r_r   <= w_r_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_quot  <= w_q_next;
                        r_rem   <= w_r_next;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_DZERO: begin
                    // Q still holds the untouched dividend here.
                    r_quot  <= '1;
                    r_rem   <= r_q;
                    r_dbz   <= 1'b1;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_seq_divider                                                   |
// | Self-checking bench for seq_divider against an arithmetic model. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int done_exp = 0;

    seq_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and follow it to its done pulse. A nonzero inj
    // injects a spurious start (1 / 1) that many cycles after acceptance.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int inj);
        int          cyc;
        logic [31:0] eq;
        logic [31:0] er;
        if (b == 0) begin
            eq = 32'((1 << W) - 1);
            er = 32'(a);
        end else begin
            eq = 32'(a) / 32'(b);
            er = 32'(a) % 32'(b);
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("accept_busy", 32'(busy), 1);
        chk("accept_done", 32'(done), 0);
        chk("accept_dbz", 32'(div_by_zero), 0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            chk("busy_run", 32'(busy), 1);
            if (inj != 0 && cyc == inj) begin
                dividend = 4'd1;
                divisor  = 4'd1;
                start    = 1'b1;
            end else begin
                dividend = W'($urandom);
                divisor  = W'($urandom);
                start    = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        chk("latency", 32'(cyc), (b == 0) ? 32'd1 : 32'(W));
        chk("done_busy", 32'(busy), 0);
        chk("quotient", 32'(quotient), eq);
        chk("remainder", 32'(remainder), er);
        chk("div_by_zero", 32'(div_by_zero), (b == 0) ? 32'd1 : 32'd0);
        done_exp++;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_quot", 32'(quotient), 0);
        chk("rst_rem", 32'(remainder), 0);
        chk("rst_dbz", 32'(div_by_zero), 0);
        rst = 1'b0;
        tick();

        run_op(4'd13, 4'd4, 0);
        tick();

        // Second start issued in the done cycle of the first.
        run_op(4'd15, 4'd15, 0);
        run_op(4'd3, 4'd7, 0);
        tick();

        run_op(4'd9, 4'd0, 0);
        run_op(4'd8, 4'd2, 0);
        tick();

        run_op(4'd12, 4'd5, 2);
        tick();

        // Abort 14 / 3 with reset at the second iteration edge.
        dividend = 4'd14;
        divisor  = 4'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_quot", 32'(quotient), 0);
        chk("abort_rem", 32'(remainder), 0);
        chk("abort_dbz", 32'(div_by_zero), 0);
        rst = 1'b0;
        tick();
        run_op(4'd14, 4'd3, 0);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 1) tick();
            run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if ($urandom_range(0, 1) == 1) tick();
                run_op(W'(a), W'(b), 0);
            end
        end

        tick();
        tick();
        chk("done_count", 32'(done_seen), 32'(done_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider. It is the inverse-operation companion to the team's 4-bit adder/subtractor.
- Repeatedly uses subtract mode (shift, trial-subtract, restore) to produce a quotient and remainder.
- Sits beside the adder/subtractor in the arithmetic lab datapath. A start/done handshake lets a controller or bench issue operations back-to-back.

Parameters:
- WIDTH, 4, operand/quotient/remainder width in bits (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while idle
- dividend  input  WIDTH  unsigned dividend, captured on accepted start
- divisor  input  WIDTH  unsigned divisor, captured on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; results valid
- quotient  output  WIDTH  unsigned quotient, held until next accepted start
- remainder  output  WIDTH  unsigned remainder, held until next accepted start
- div_by_zero  output  1  set with done when captured divisor == 0; held like quotient

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state = IDLE
  - busy = 0, done = 0, div_by_zero = 0
  - quotient = 0, remainder = 0
  - iteration counter = 0
- rst has priority over everything. Asserting it mid-operation aborts the operation: state returns to IDLE and all outputs take their reset values at that edge.
- States: IDLE, RUN, DZERO.
- IDLE, on an edge with start = 1:
  - Capture dividend into shift register Q and divisor into D.
  - Clear partial remainder R (WIDTH+1 bits).
  - Clear counter, clear done, set busy.
  - Next state is RUN if divisor != 0, else DZERO.
- RUN, each edge, one iteration:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, D}, computed in WIDTH+1 bits. No borrow means T >= 0.
  - No borrow: R = T, shift Q left inserting 1.
  - Borrow: R = {R[WIDTH-1:0], Q[WIDTH-1]} (restore), shift Q left inserting 0.
  - Counter increments.
  - On the WIDTH-th iteration edge: quotient = final Q, remainder = final R[WIDTH-1:0], done = 1, busy = 0, state = IDLE.
- DZERO, one edge:
  - quotient = all ones, remainder = captured dividend, div_by_zero = 1.
  - done = 1, busy = 0, state = IDLE.
- Latency, with start accepted at edge N:
  - Normal: done high from edge N+WIDTH to edge N+WIDTH+1.
  - Divide-by-zero: done high from edge N+1 to edge N+2.
  - busy high from edge N until done rises.
- done is deasserted on the next edge unless a new completion occurs.
- div_by_zero is cleared on the next accepted start.
- A start while busy is ignored. It is neither queued nor does it corrupt captured operands.
- Back-to-back: the cycle in which done = 1 is IDLE, so a start there is accepted. done falls at that same edge.
- Operands may change while busy without effect.
- Arithmetic is unsigned only; no overflow is possible for a nonzero divisor. The identity dividend = quotient*divisor + remainder holds, with remainder < divisor.

Decomposition:
- Shared package seq_div_pkg:
  - state encoding constants ST_IDLE, ST_RUN, ST_DZERO.
  - default WIDTH constant.
  - counter width constant = clog2(WIDTH)+1.
- One natural sub-module: div_step. It is a combinational single iteration built on the trial subtract.
  - Inputs: R, Q msb, D.
  - Outputs: next R, quotient bit.
- seq_divider holds the FSM, registers, counter and handshake.

Test Plan:
- WIDTH=4, rst held 2 cycles, then start with 13 / 4: done exactly 4 edges after accept; quotient = 3, remainder = 1, div_by_zero = 0; busy high for 4 cycles.
- 15 / 15 -> quotient = 1, remainder = 0. Then 3 / 7 -> quotient = 0, remainder = 3. Second start issued in the done cycle is accepted, giving back-to-back results with no idle gap.
- 9 / 0 -> done 1 edge after accept; div_by_zero = 1, quotient = 4'b1111, remainder = 9. Next start of 8 / 2 clears div_by_zero and gives quotient = 4, remainder = 0.
- Start 12 / 5; two cycles later pulse start with 1 / 1 and change operands: it is ignored, and results are quotient = 2, remainder = 2 at the expected edge.
- Start 14 / 3; assert rst at iteration 2: at that edge busy = 0, done = 0, outputs zero, state IDLE. A later 14 / 3 gives quotient = 4, remainder = 2.
- Exhaustive sweep of all 256 operand pairs with a reference model: quotient, remainder and div_by_zero match, and done pulses exactly once per accepted start.
